// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
package bp_pkg;

  localparam int unsigned BP_XLEN    = 32;
  localparam int unsigned BP_ENTRIES = 64;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_t;

  // Tag is stored zero-extended to the full address width.
  typedef struct packed {
    logic               valid;
    logic [BP_XLEN-1:0] tag;
    logic [BP_XLEN-1:0] target;
    bp_ctr_t            ctr;
  } bp_entry_t;

  // Saturating step towards the resolved outcome.
  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t next;
    next = ctr;
    unique case (ctr)
      STRONG_NT: next = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   next = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    next = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  next = taken ? STRONG_T : WEAK_T;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module perf_sat_counter #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_sat;

  assign w_sat   = &r_count;
  assign o_count = r_count;

  // Count enabled events until the counter is saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RESET_VAL;
    end else if (i_en && !w_sat) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit counter BHT,
// trained from the execute-stage branch resolution.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned XLEN    = BP_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            predict_taken_f,
  output logic [XLEN-1:0] predict_target_f,
  input  logic            update_en_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic            branch_taken_e,
  input  logic [XLEN-1:0] branch_target_e,
  input  logic            branch_mispredict_e,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  bp_entry_t r_table [ENTRIES];

  logic [IDX_W-1:0]   w_idx_f;
  logic [BP_XLEN-1:0] w_tag_f;
  bp_entry_t          w_entry_f;
  logic               w_hit_f;

  logic [IDX_W-1:0]   w_idx_e;
  logic [BP_XLEN-1:0] w_tag_e;
  bp_entry_t          w_entry_e;
  logic               w_hit_e;

  logic               w_unused_pc_lsbs;

  // Instructions are word aligned, so the low PC bits carry no information.
  assign w_unused_pc_lsbs = ^{pc_f[1:0], pc_e[1:0]};

  // Fetch-side lookup, purely combinational from registered state.
  always_comb begin
    w_idx_f          = pc_f[IDX_W+1:2];
    w_tag_f          = BP_XLEN'(pc_f[XLEN-1:IDX_W+2]);
    w_entry_f        = r_table[w_idx_f];
    w_hit_f          = w_entry_f.valid && (w_entry_f.tag == w_tag_f);
    predict_taken_f  = w_hit_f && w_entry_f.ctr[1];
    predict_target_f = predict_taken_f ? XLEN'(w_entry_f.target) : pc_f + XLEN'(4);
  end

  // Execute-side hit detection for training.
  always_comb begin
    w_idx_e   = pc_e[IDX_W+1:2];
    w_tag_e   = BP_XLEN'(pc_e[XLEN-1:IDX_W+2]);
    w_entry_e = r_table[w_idx_e];
    w_hit_e   = w_entry_e.valid && (w_entry_e.tag == w_tag_e);
  end

  // Table training: update counter/target on hit, allocate on a taken miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_table[i].valid  <= 1'b0;
        r_table[i].tag    <= '0;
        r_table[i].target <= '0;
        r_table[i].ctr    <= WEAK_NT;
      end
    end else if (update_en_e) begin
      if (w_hit_e) begin
        r_table[w_idx_e].ctr <= bp_ctr_next(w_entry_e.ctr, branch_taken_e);
        if (branch_taken_e) begin
          r_table[w_idx_e].target <= BP_XLEN'(branch_target_e);
        end
      end else if (branch_taken_e) begin
        // Replace whatever aliasing entry occupies this slot.
        r_table[w_idx_e].valid  <= 1'b1;
        r_table[w_idx_e].tag    <= w_tag_e;
        r_table[w_idx_e].target <= BP_XLEN'(branch_target_e);
        r_table[w_idx_e].ctr    <= WEAK_T;
      end
    end
  end

  perf_sat_counter #(
    .WIDTH     (32),
    .RESET_VAL (32'h0)
  ) u_perf_branches (
    .clk     (clk),
    .rst     (rst),
    .i_en    (update_en_e),
    .o_count (perf_branches)
  );

  perf_sat_counter #(
    .WIDTH     (32),
    .RESET_VAL (32'h0)
  ) u_perf_mispredicts (
    .clk     (clk),
    .rst     (rst),
    .i_en    (update_en_e && branch_mispredict_e),
    .o_count (perf_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

  localparam int NENT = 64;
  localparam longint SATMAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        predict_taken_f;
  logic [31:0] predict_target_f;
  logic        update_en_e;
  logic [31:0] pc_e;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic        branch_mispredict_e;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  logic        sat_en;
  logic [31:0] sat_count;

  int checks;
  int errors;

  // Behavioural model state
  bit          m_valid  [NENT];
  int unsigned m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_ctr    [NENT];
  longint      m_br;
  longint      m_mp;
  longint      m_sat;

  branch_predictor #(
    .ENTRIES (64),
    .XLEN    (32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_f                (pc_f),
    .predict_taken_f     (predict_taken_f),
    .predict_target_f    (predict_target_f),
    .update_en_e         (update_en_e),
    .pc_e                (pc_e),
    .branch_taken_e      (branch_taken_e),
    .branch_target_e     (branch_target_e),
    .branch_mispredict_e (branch_mispredict_e),
    .perf_branches       (perf_branches),
    .perf_mispredicts    (perf_mispredicts)
  );

  perf_sat_counter #(
    .WIDTH     (32),
    .RESET_VAL (32'hFFFF_FFFE)
  ) u_sat (
    .clk     (clk),
    .rst     (rst),
    .i_en    (sat_en),
    .o_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
    end
    m_br  = 0;
    m_mp  = 0;
    m_sat = 64'h0000_0000_FFFF_FFFE;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit tk,
                                       output logic [31:0] tgt);
    int unsigned idx;
    int unsigned tag;
    idx = (pc >> 2) % NENT;
    tag = pc >> 8;
    tk  = m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
    tgt = tk ? m_target[idx] : pc + 32'd4;
  endfunction

  function automatic void model_update(input bit en, input logic [31:0] pc, input bit tk,
                                       input logic [31:0] tgt, input bit mp, input bit sen);
    int unsigned idx;
    int unsigned tag;
    if (sen && m_sat < SATMAX) m_sat++;
    if (!en) return;
    if (m_br < SATMAX) m_br++;
    if (mp && m_mp < SATMAX) m_mp++;
    idx = (pc >> 2) % NENT;
    tag = pc >> 8;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      m_ctr[idx] = tk ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                      : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
      if (tk) m_target[idx] = tgt;
    end else if (tk) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = tag;
      m_target[idx] = tgt;
      m_ctr[idx]    = 2;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pred(input string tag);
    bit          et;
    logic [31:0] etg;
    #1;
    model_lookup(pc_f, et, etg);
    chk({tag, ".taken"}, {31'b0, predict_taken_f}, {31'b0, et});
    chk({tag, ".target"}, predict_target_f, etg);
  endtask

  task automatic check_perf(input string tag);
    chk({tag, ".br"}, perf_branches, m_br[31:0]);
    chk({tag, ".mp"}, perf_mispredicts, m_mp[31:0]);
  endtask

  // One clock edge; the model sees the inputs held across that edge.
  task automatic step();
    @(posedge clk);
    model_update(update_en_e, pc_e, branch_taken_e, branch_target_e, branch_mispredict_e,
                 sat_en);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input bit mp);
    update_en_e         = 1'b1;
    pc_e                = pc;
    branch_taken_e      = tk;
    branch_target_e     = tgt;
    branch_mispredict_e = mp;
    step();
    update_en_e         = 1'b0;
    branch_mispredict_e = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    logic [31:0] i;
    t = $urandom_range(0, 3);
    i = $urandom_range(0, 7);
    return (t << 8) | (i << 2) | ($urandom() & 32'h3);
  endfunction

  initial begin
    checks              = 0;
    errors              = 0;
    rst                 = 1'b1;
    pc_f                = 32'h100;
    update_en_e         = 1'b0;
    pc_e                = '0;
    branch_taken_e      = 1'b0;
    branch_target_e     = '0;
    branch_mispredict_e = 1'b0;
    sat_en              = 1'b0;
    model_reset();

    // 1: reset state
    #12;
    rst = 1'b0;
    check_pred("t1");
    chk("t1.taken_c", {31'b0, predict_taken_f}, 32'h0);
    chk("t1.target_c", predict_target_f, 32'h104);
    chk("t1.br_c", perf_branches, 32'h0);
    chk("t1.mp_c", perf_mispredicts, 32'h0);
    pc_f = 32'hFFFF_FFFC;
    check_pred("t1.wrap");
    chk("t1.wrap_c", predict_target_f, 32'h0);
    step();

    // 2: allocate and strengthen
    upd(32'h100, 1'b1, 32'h080, 1'b0);
    pc_f = 32'h100;
    check_pred("t2.alloc");
    chk("t2.target_c", predict_target_f, 32'h080);
    pc_f = 32'h102;
    check_pred("t2.lsb_ignored");
    upd(32'h100, 1'b1, 32'h080, 1'b0);
    upd(32'h100, 1'b1, 32'h080, 1'b0);
    pc_f = 32'h100;
    check_pred("t2.strong");

    // 3: decrement, saturate low, single taken stays not-taken
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    check_pred("t3.weak_t");
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    check_pred("t3.weak_nt");
    chk("t3.target_c", predict_target_f, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b1, 32'h080, 1'b0);
    check_pred("t3.from_sat");
    chk("t3.taken_c", {31'b0, predict_taken_f}, 32'h0);
    upd(32'h100, 1'b1, 32'h080, 1'b0);
    check_pred("t3.back_to_t");

    // 4: aliasing on index 0
    pc_f = 32'h200;
    check_pred("t4.alias_miss");
    upd(32'h200, 1'b0, 32'h0, 1'b0);
    pc_f = 32'h100;
    check_pred("t4.still_hit");
    chk("t4.still_hit_c", {31'b0, predict_taken_f}, 32'h1);
    upd(32'h200, 1'b1, 32'h300, 1'b0);
    pc_f = 32'h200;
    check_pred("t4.replaced");
    chk("t4.replaced_c", predict_target_f, 32'h300);
    pc_f = 32'h100;
    check_pred("t4.evicted");

    // 5: same-cycle lookup/update, then asynchronous reset
    do_reset();
    update_en_e     = 1'b1;
    pc_e            = 32'h100;
    branch_taken_e  = 1'b1;
    branch_target_e = 32'h040;
    pc_f            = 32'h100;
    check_pred("t5.same_cycle");
    step();
    update_en_e = 1'b0;
    check_pred("t5.next_cycle");
    chk("t5.next_cycle_c", predict_target_f, 32'h040);
    #2;
    rst = 1'b1;
    model_reset();
    check_pred("t5.async_rst");
    chk("t5.async_rst_c", {31'b0, predict_taken_f}, 32'h0);
    check_perf("t5.async_rst");
    #1;
    rst = 1'b0;
    step();

    // 6: perf counters, update_en gating, saturation
    upd(32'h010, 1'b1, 32'h500, 1'b1);
    upd(32'h014, 1'b0, 32'h0,   1'b0);
    upd(32'h010, 1'b1, 32'h500, 1'b1);
    upd(32'h018, 1'b0, 32'h0,   1'b0);
    upd(32'h01C, 1'b1, 32'h600, 1'b0);
    branch_mispredict_e = 1'b1;
    branch_taken_e      = 1'b1;
    pc_e                = 32'h020;
    step();
    branch_mispredict_e = 1'b0;
    check_perf("t6");
    chk("t6.br_c", perf_branches, 32'd5);
    chk("t6.mp_c", perf_mispredicts, 32'd2);
    pc_f = 32'h020;
    check_pred("t6.no_update_when_idle");
    chk("t6.sat_preload", sat_count, 32'hFFFF_FFFE);
    sat_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6.sat%0d", k), sat_count, m_sat[31:0]);
    end
    sat_en = 1'b0;
    chk("t6.sat_c", sat_count, 32'hFFFF_FFFF);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      update_en_e         = ($urandom_range(0, 3) != 0);
      pc_e                = rand_pc();
      branch_taken_e      = $urandom_range(0, 1);
      branch_target_e     = $urandom() & 32'hFFFF_FFFC;
      branch_mispredict_e = $urandom_range(0, 1);
      pc_f                = ($urandom_range(0, 1) != 0) ? pc_e : rand_pc();
      check_pred($sformatf("rnd%0d", n));
      step();
      check_perf($sformatf("rnd%0d", n));
    end
    update_en_e = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage branch predictor: the prediction end of the branch resolution path. It combines a direct-mapped BTB with a 2-bit saturating-counter BHT.
- Fetch: predicts taken/target for pc_f each cycle.
- Execute: trained by the resolved outcome of each conditional branch (branch_taken, branch_mispredict from the execute branch comparator).
- Keeps saturating performance counters for branches and mispredictions.

Parameters:
ENTRIES, 64, number of BTB/BHT entries (power of 2, ≥4)
XLEN, 32, address width
IDX_W, $clog2(ENTRIES), derived localparam; index = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2]

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pc_f  in  XLEN  fetch PC
predict_taken_f  out  1  predict taken for pc_f
predict_target_f  out  XLEN  next-PC prediction for pc_f
update_en_e  in  1  resolved conditional branch in execute (Branch & not flushed)
pc_e  in  XLEN  PC of resolving branch
branch_taken_e  in  1  actual outcome
branch_target_e  in  XLEN  actual taken target
branch_mispredict_e  in  1  comparator mispredict flag (counted only)
perf_branches  out  32  resolved branch count
perf_mispredicts  out  32  mispredict count

Behaviour:
- Entry state: valid, tag, target, ctr[1:0]. Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, takes effect immediately, including mid-update):
  - Every entry: valid=0, ctr=01.
  - perf_branches = perf_mispredicts = 0.
  - pc_f-dependent outputs therefore read predict_taken_f=0, predict_target_f=pc_f+4.
- Lookup (combinational, zero latency, from registered state):
  - hit = valid[idx_f] & (tag[idx_f]==tag(pc_f)).
  - predict_taken_f = hit & ctr[idx_f][1].
  - predict_target_f = predict_taken_f ? target[idx_f] : pc_f+4 (mod 2^XLEN; wraps at top of address space).
  - pc_f[1:0] is ignored.
- Update (posedge clk, only when update_en_e=1):
  - Hit at pc_e: ctr saturating +1 if taken, -1 if not taken. 11 stays 11 on taken; 00 stays 00 on not-taken.
  - Hit and taken: target <= branch_target_e.
  - Miss and taken: allocate, replacing any aliasing entry. valid=1, tag=tag(pc_e), target=branch_target_e, ctr=10.
  - Miss and not taken: no state change.
  - update_en_e=0: tables unchanged regardless of other inputs.
- Same-cycle lookup and update at the same index: lookup returns pre-update state (no bypass). New state is visible from the next cycle.
- Perf counters, per cycle with update_en_e=1:
  - perf_branches += 1.
  - perf_mispredicts += branch_mispredict_e.
  - Both saturate at 32'hFFFF_FFFF (no wrap).
  - branch_mispredict_e is ignored when update_en_e=0.
- Single write port, so no write-write conflicts.

Decomposition:
- Package bp_pkg:
  - bp_ctr_t enum (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T).
  - bp_entry_t struct (valid, tag, target, ctr).
  - Function bp_ctr_next(ctr, taken) implementing the saturating update.
- Sub-module perf_sat_counter: 32-bit saturating increment with enable and async reset, instantiated twice.

Test Plan:
All cases use ENTRIES=64, so idx = pc[7:2] and tag = pc[31:8].
1. Assert rst, release; pc_f=0x100 -> predict_taken_f=0, predict_target_f=0x104, both perf counters 0.
2. Update pc_e=0x100, taken, target=0x080 -> next cycle pc_f=0x100 gives predict_taken_f=1, target=0x080 (ctr=10). A second taken update gives ctr=11; a third stays 11.
3. From ctr=11 at 0x100, apply not-taken ×2 -> ctr=01, predict 0, target 0x104. Then not-taken ×2 -> ctr=00 (saturated). Then one taken -> ctr=01, still predicts 0.
4. Aliasing, with 0x100 allocated: pc_f=0x200 (same idx 0, tag 2) -> miss, predict 0. A not-taken update at 0x200 causes no allocation, and 0x100 still hits. A taken update at 0x200, target 0x300, replaces the entry -> 0x200 predicts 1/0x300; 0x100 now misses.
5. Same-cycle pc_f=0x100 and taken update at 0x100 on an empty table -> predict 0 that cycle, 1/target the next cycle. Then assert rst mid-cycle -> predict 0 immediately, without waiting for a clock edge.
6. Issue 5 updates, 2 with branch_mispredict_e=1, plus 1 cycle with update_en_e=0 and mispredict=1 -> perf_branches=5, perf_mispredicts=2. Preload near 32'hFFFF_FFFE and apply 3 updates -> saturates at 32'hFFFF_FFFF.
